// File: rtl/execute_cc_stage.sv
// Y86-64 execute-stage condition codes, branch/cmov condition and E->M pipeline register.
// Optional sticky overflow trap built only when CC_TRAP_EN is defined.
module execute_cc_stage #(
  parameter int          WIDTH = 64,
  parameter logic [3:0]  RNONE = 4'hF,
  parameter logic [3:0]  I_NOP = 4'h1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       e_icode,
  input  logic [3:0]       e_ifun,
  input  logic [3:0]       e_dstE,
  input  logic [WIDTH-1:0] alu_sum,
  input  logic             alu_overflow,
  input  logic             alu_carry,
  input  logic             set_cc,
  input  logic             m_stall,
  input  logic             m_bubble,
  output logic [2:0]       cc,
  output logic             e_cnd,
  output logic             M_valid,
  output logic [3:0]       M_icode,
  output logic             M_cnd,
  output logic [WIDTH-1:0] M_valE,
  output logic [3:0]       M_dstE,
  output logic             M_carry,
  output logic             ovf_trap
);

  localparam logic [3:0] I_CMOV = 4'h2;
  localparam logic [3:0] I_OPQ  = 4'h6;
  localparam logic [3:0] I_JXX  = 4'h7;

  // codes = {ZF,SF,OF}
  function automatic logic cond_eval(input logic [2:0] codes, input logic [3:0] fn);
    logic zf;
    logic sf;
    logic of;
    logic res;
    zf = codes[2];
    sf = codes[1];
    of = codes[0];
    case (fn)
      4'h0:    res = 1'b1;
      4'h1:    res = (sf ^ of) | zf;
      4'h2:    res = sf ^ of;
      4'h3:    res = zf;
      4'h4:    res = ~zf;
      4'h5:    res = ~(sf ^ of);
      4'h6:    res = ~(sf ^ of) & ~zf;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  logic [2:0]       cc_r;
  logic             cnd_s;
  logic [3:0]       dste_s;
  logic             cc_upd_s;
  logic             m_valid_r;
  logic [3:0]       m_icode_r;
  logic             m_cnd_r;
  logic [WIDTH-1:0] m_vale_r;
  logic [3:0]       m_dste_r;
  logic             m_carry_r;

  // Condition evaluation, effective destination and CC update enable
  always_comb begin
    cnd_s    = 1'b1;
    dste_s   = e_dstE;
    cc_upd_s = 1'b0;
    if (e_icode == I_CMOV || e_icode == I_JXX) begin
      cnd_s = cond_eval(cc_r, e_ifun);
    end else begin
      cnd_s = 1'b1;
    end
    if (e_icode == I_CMOV && !cnd_s) begin
      dste_s = RNONE;
    end else begin
      dste_s = e_dstE;
    end
    cc_upd_s = in_valid && (e_icode == I_OPQ) && set_cc && !m_stall;
  end

  // Condition-code register
  always_ff @(posedge clk) begin
    if (rst) begin
      cc_r <= 3'b100;
    end else if (cc_upd_s) begin
      cc_r <= {(alu_sum == {WIDTH{1'b0}}), alu_sum[WIDTH-1], alu_overflow};
    end else begin
      cc_r <= cc_r;
    end
  end

  // E->M pipeline register: rst > stall > bubble > load
  always_ff @(posedge clk) begin
    if (rst || (!m_stall && m_bubble)) begin
      m_valid_r <= 1'b0;
      m_icode_r <= I_NOP;
      m_cnd_r   <= 1'b0;
      m_vale_r  <= {WIDTH{1'b0}};
      m_dste_r  <= RNONE;
      m_carry_r <= 1'b0;
    end else if (m_stall) begin
      m_valid_r <= m_valid_r;
      m_icode_r <= m_icode_r;
      m_cnd_r   <= m_cnd_r;
      m_vale_r  <= m_vale_r;
      m_dste_r  <= m_dste_r;
      m_carry_r <= m_carry_r;
    end else begin
      m_valid_r <= in_valid;
      m_icode_r <= e_icode;
      m_cnd_r   <= in_valid ? cnd_s : 1'b0;
      m_vale_r  <= alu_sum;
      m_dste_r  <= in_valid ? dste_s : RNONE;
      m_carry_r <= alu_carry;
    end
  end

`ifdef CC_TRAP_EN
  logic trap_r;

  // Sticky overflow trap, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      trap_r <= 1'b0;
    end else if (cc_upd_s && alu_overflow) begin
      trap_r <= 1'b1;
    end else begin
      trap_r <= trap_r;
    end
  end

  assign ovf_trap = trap_r;
`else
  assign ovf_trap = 1'b0;
`endif

  assign cc      = cc_r;
  assign e_cnd   = cnd_s;
  assign M_valid = m_valid_r;
  assign M_icode = m_icode_r;
  assign M_cnd   = m_cnd_r;
  assign M_valE  = m_vale_r;
  assign M_dstE  = m_dste_r;
  assign M_carry = m_carry_r;

endmodule
